ahb_sram_slave: RTL

AHB-Lite slave with a word-organised SRAM. It sits directly downstream of the AHB-Lite bus interface and responds to the HTRANS/HADDR/HWRITE/HSIZE/HWDATA transfers a master drives onto it. It returns HRDATA, HREADYout and HRESP. It is also the primary DUT behind the team's AHB UVM environment. Wait-state insertion is configurable, and it gives a two-cycle ERROR response on illegal accesses.

---
 rtl/ahb_sram_slave.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a word-wide SRAM; zero-wait data phase plus WAIT_STATES stall cycles, two-cycle ERROR on illegal access.
// Stalls the bus with HREADYout low; accepts a new address phase only on an edge where HREADYin is high.
module ahb_sram_slave #(
    parameter int unsigned MEM_DEPTH_LOG2 = 10,
    parameter int unsigned WAIT_STATES    = 0
) (
    input  logic        HCLK,
    input  logic        HRESET_n,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HBURST,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADYin,
    output logic        HREADYout,
    output logic [31:0] HRDATA,
    output logic [1:0]  HRESP
);

    localparam int unsigned AW    = MEM_DEPTH_LOG2 + 2;
    localparam int unsigned DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     wait_cnt_q, wait_cnt_d;
    logic           dp_valid_q, dp_valid_d;
    logic           dp_write_q, dp_write_d;
    logic [1:0]     dp_size_q, dp_size_d;
    logic [AW-1:0]  dp_addr_q, dp_addr_d;

    logic [31:0]    mem [DEPTH];
    logic [31:0]    rd_word;
    logic [3:0]     lane_we;
    logic           accept;
    logic           acc_err;
    logic           dp_done;

    // Burst type is not needed: every beat carries its own address.
    logic unused_hburst;
    assign unused_hburst = ^HBURST;

    assign accept = HSEL & HREADYin & HTRANS[1];

    always_comb begin
        acc_err = 1'b0;
        if (HSIZE > 3'b010)                          acc_err = 1'b1;
        if (HSIZE == 3'b001 && HADDR[0])             acc_err = 1'b1;
        if (HSIZE == 3'b010 && HADDR[1:0] != 2'b00)  acc_err = 1'b1;
        if ((HADDR >> AW) != 32'd0)                  acc_err = 1'b1;
    end

    // Only legal transfers hold dp_valid, so completion is simply "pending and ready".
    assign dp_done   = dp_valid_q && (state_q == S_IDLE);
    assign HREADYout = (state_q == S_IDLE) || (state_q == S_ERR2);
    assign HRESP     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01 : 2'b00;
    assign rd_word   = mem[dp_addr_q[AW-1:2]];
    assign HRDATA    = (dp_done && !dp_write_q) ? rd_word : 32'd0;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_size_d  = dp_size_q;
        dp_addr_d  = dp_addr_q;
        unique case (state_q)
            S_IDLE, S_ERR2: begin
                state_d    = S_IDLE;
                dp_valid_d = 1'b0;
                if (accept) begin
                    dp_write_d = HWRITE;
                    dp_size_d  = HSIZE[1:0];
                    dp_addr_d  = HADDR[AW-1:0];
                    if (acc_err) begin
                        state_d = S_ERR1;
                    end else begin
                        dp_valid_d = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_d    = S_WAIT;
                            wait_cnt_d = WS_LOAD;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_ERR1: begin
                state_d = S_ERR2;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESET_n) begin
        if (!HRESET_n) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_size_q  <= 2'b00;
            dp_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_size_q  <= dp_size_d;
            dp_addr_q  <= dp_addr_d;
        end
    end

    // Byte lanes follow the latched address; HWDATA is already lane-aligned by the master.
    always_comb begin
        lane_we = 4'b0000;
        if (dp_done && dp_write_q) begin
            unique case (dp_size_q)
                2'b00:   lane_we[dp_addr_q[1:0]] = 1'b1;
                2'b01:   lane_we = dp_addr_q[1] ? 4'b1100 : 4'b0011;
                default: lane_we = 4'b1111;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) begin
                mem[dp_addr_q[AW-1:2]][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

endmodule
